// File: rtl/random_food_pkg.sv
// Shared types and constants for the food generator: FSM states, LFSR taps, default playfield size.
// Pure declarations; no logic of its own.
package random_food_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_CHECK,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as a bit mask over a 16-bit register
  localparam logic [15:0] LFSR_TAPS16 = 16'hB400;

  localparam int DEF_COLS    = 64;
  localparam int DEF_ROWS    = 48;
  localparam int DEF_CELL_PX = 10;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/food_lfsr.sv
// Free-running Fibonacci LFSR, shifts left each cycle with feedback into bit 0; exposes its state.
// Zero latency to state; no backpressure (never stalls). A zero seed is replaced by 1.
module food_lfsr #(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = W'(16'hACE1),
  parameter logic [W-1:0] TAPS = W'(16'hB400)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] RST_VAL = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= RST_VAL;
    else        lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/random_food_gen.sv
// Food placer: LFSR candidate cells, range check, occupancy query, redraw; RANDOM_FOOD_BORDER_EN keeps food off the wall ring.
// req->valid in 4 cycles minimum, +3 per occupied retry, +1 per range reject; req ignored unless IDLE.
module random_food_gen
  import random_food_pkg::*;
#(
  parameter int                COLS      = DEF_COLS,
  parameter int                ROWS      = DEF_ROWS,
  parameter int                CELL_PX   = DEF_CELL_PX,
  parameter int                X_W       = 10,
  parameter int                Y_W       = 9,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int                MAX_TRIES = 255,
  localparam int               CW        = clog2(COLS),
  localparam int               RW        = clog2(ROWS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  output logic           busy,
  output logic           valid,
  output logic           fail,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           chk_valid,
  output logic [CW-1:0]  chk_col,
  output logic [RW-1:0]  chk_row,
  input  logic           occupied
);

  localparam int          TW        = clog2(MAX_TRIES + 1);
  localparam logic [31:0] CELL_PX_U = 32'(CELL_PX);

  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;
  logic [CW-1:0]     cand_col;
  logic [RW-1:0]     cand_row;
  logic              cand_bad;
  logic [31:0]       px_x;
  logic [31:0]       px_y;

  state_e            state_q, state_d;
  logic [TW-1:0]     tries_q, tries_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [X_W-1:0]    food_x_q, food_x_d;
  logic [Y_W-1:0]    food_y_q, food_y_d;

  food_lfsr #(
    .W    (LFSR_W),
    .SEED (SEED),
    .TAPS (LFSR_W'(LFSR_TAPS16))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst),
    .state (lfsr)
  );

  assign unused_lfsr = ^lfsr;
  assign cand_col    = lfsr[CW-1:0];
  assign cand_row    = lfsr[CW+RW-1:CW];

`ifdef RANDOM_FOOD_BORDER_EN
  assign cand_bad = (int'(cand_col) >= COLS) || (int'(cand_row) >= ROWS) ||
                    (cand_col == '0) || (int'(cand_col) == COLS - 1) ||
                    (cand_row == '0) || (int'(cand_row) == ROWS - 1);
`else
  assign cand_bad = (int'(cand_col) >= COLS) || (int'(cand_row) >= ROWS);
`endif

  assign px_x = 32'(col_q) * CELL_PX_U;
  assign px_y = 32'(row_q) * CELL_PX_U;

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    col_d    = col_q;
    row_d    = row_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_DRAW;
          tries_d = '0;
        end
      end
      S_DRAW: begin
        tries_d = tries_q + TW'(1);
        // only accepted cells are latched so the query bus holds the last queried cell
        if (!cand_bad) begin
          col_d   = cand_col;
          row_d   = cand_row;
          state_d = S_CHECK;
        end else if (tries_d == TW'(MAX_TRIES)) begin
          state_d = S_FAIL;
        end
      end
      S_CHECK: state_d = S_WAIT;
      S_WAIT: begin
        if (!occupied) begin
          state_d  = S_DONE;
          food_x_d = px_x[X_W-1:0];
          food_y_d = px_y[Y_W-1:0];
        end else if (tries_q == TW'(MAX_TRIES)) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_DRAW;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tries_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      food_x_q <= '0;
      food_y_q <= '0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      col_q    <= col_d;
      row_q    <= row_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
    end
  end

  assign busy      = (state_q == S_DRAW) || (state_q == S_CHECK) || (state_q == S_WAIT);
  assign valid     = (state_q == S_DONE) || (state_q == S_FAIL);
  assign fail      = (state_q == S_FAIL);
  assign chk_valid = (state_q == S_CHECK);
  assign chk_col   = col_q;
  assign chk_row   = row_q;
  assign food_x    = food_x_q;
  assign food_y    = food_y_q;

endmodule

// File: tb/tb_random_food_gen.sv
// Bench for random_food_gen: LFSR golden sequence, table of request scenarios, reset abort, range sweep.
`timescale 1ns/1ps
module tb_random_food_gen;

  localparam int MAXT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       occupied = 1'b0;
  logic       busy, valid, fail, chk_valid;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic [5:0] chk_col;
  logic [5:0] chk_row;

  random_food_gen #(.MAX_TRIES(MAXT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .busy      (busy),
    .valid     (valid),
    .fail      (fail),
    .food_x    (food_x),
    .food_y    (food_y),
    .chk_valid (chk_valid),
    .chk_col   (chk_col),
    .chk_row   (chk_row),
    .occupied  (occupied)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lnext(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic bit in_range(input logic [15:0] x);
    int c, r;
    c = int'(x[5:0]);
    r = int'(x[11:6]);
`ifdef RANDOM_FOOD_BORDER_EN
    return (c > 0) && (c < 63) && (r > 0) && (r < 47);
`else
    return (c < 64) && (r < 48);
`endif
  endfunction

  // reference LFSR running alongside the DUT, used to plan requests
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lnext(m_lfsr);
  end

  int cyc = 0;
  int zero_hits = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst && dut.lfsr == 16'h0000) zero_hits++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int rej;       // first draw must be range-rejected
    int n_occ;     // queries answered occupied before a free one
    int hold;      // keep req high through busy and the valid cycle
    int exp_fail;
    int exp_lat;
    int exp_chk;
  } vec_t;

  vec_t       vecs[8];
  logic [5:0] pc[8];
  logic [5:0] pr[8];
  logic [9:0] exp_fx = '0;
  logic [8:0] exp_fy = '0;

  // caller is at #1 after a posedge with the DUT idle
  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] s;
    bit          ok, got_valid, got_fail;
    int          nd, lat, nchk, busy_bad;
    v  = vecs[idx];
    nd = (v.n_occ + 1 > MAXT) ? MAXT : v.n_occ + 1;
    ok = 1'b0;
    for (int w = 0; w < 1000 && !ok; w++) begin
      s  = lnext(m_lfsr);
      ok = 1'b1;
      if (v.rej != 0) begin
        if (in_range(s)) ok = 1'b0;
        s = lnext(s);
      end
      for (int k = 0; k < nd; k++) begin
        if (!in_range(s)) ok = 1'b0;
        pc[k] = s[5:0];
        pr[k] = s[11:6];
        s = lnext(lnext(lnext(s)));
      end
      if (!ok) begin
        @(posedge clk); #1;
      end
    end
    check($sformatf("v%0d_start_found", idx), ok, 1);

    req = 1'b1;
    occupied = 1'b0;
    nchk = 0; busy_bad = 0; lat = 0;
    got_valid = 1'b0; got_fail = 1'b0;
    for (int c = 1; c <= 60 && !got_valid; c++) begin
      @(posedge clk); #1;
      if (v.hold == 0) req = 1'b0;
      if (chk_valid) begin
        if (nchk < nd) begin
          check($sformatf("v%0d_q%0d_col", idx, nchk), chk_col, pc[nchk]);
          check($sformatf("v%0d_q%0d_row", idx, nchk), chk_row, pr[nchk]);
        end
        occupied = (nchk < v.n_occ);
        nchk++;
      end
      if (valid) begin
        got_valid = 1'b1;
        got_fail  = fail;
        lat       = c;
      end else if (!busy) begin
        busy_bad++;
      end
    end
    check($sformatf("v%0d_valid_seen", idx), got_valid, 1);
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_fail", idx), got_fail, v.exp_fail);
    check($sformatf("v%0d_queries", idx), nchk, v.exp_chk);
    check($sformatf("v%0d_busy_gaps", idx), busy_bad, 0);
    check($sformatf("v%0d_busy_at_valid", idx), busy, 0);
    check($sformatf("v%0d_chk_hold", idx), chk_col, pc[nd-1]);
    if (v.exp_fail == 0) begin
      exp_fx = 10'(int'(pc[nd-1]) * 10);
      exp_fy = 9'(int'(pr[nd-1]) * 10);
    end
    check($sformatf("v%0d_food_x", idx), food_x, exp_fx);
    check($sformatf("v%0d_food_y", idx), food_y, exp_fy);
    occupied = 1'b0;

    @(posedge clk); #1;
    req = 1'b0;
    check($sformatf("v%0d_req_in_valid_ignored", idx), busy, 0);
    check($sformatf("v%0d_valid_one_cycle", idx), valid, 0);
    @(posedge clk); #1;
    check($sformatf("v%0d_not_queued", idx), busy, 0);
  endtask

  initial begin
    logic [15:0] exp_l;
    bit          seen, got;
    int          n_sweep, bad_x, bad_y, timeouts, n_ok;

    vecs[0] = '{0, 0, 0, 0,  4, 1};
    vecs[1] = '{0, 1, 0, 0,  7, 2};
    vecs[2] = '{0, 3, 0, 0, 13, 4};
    vecs[3] = '{0, 8, 0, 1, 25, 8};
    vecs[4] = '{0, 0, 1, 0,  4, 1};
    vecs[5] = '{0, 2, 1, 0, 10, 3};
    vecs[6] = '{1, 0, 0, 0,  5, 1};
    vecs[7] = '{1, 1, 0, 0,  8, 2};

    #2 rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_fail", fail, 0);
    check("rst_chk_valid", chk_valid, 0);
    check("rst_food_x", food_x, 0);
    check("rst_food_y", food_y, 0);
    check("rst_lfsr", dut.lfsr, 16'hACE1);

    @(negedge clk);
    rst = 1'b1;
    exp_l = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      exp_l = lnext(exp_l);
      check($sformatf("lfsr_step%0d", i + 1), dut.lfsr, exp_l);
    end

    for (int i = 0; i < 8; i++) run_vec(i);

    // asynchronous reset while waiting for the occupancy answer
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (chk_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("mid_chk_seen", seen, 1);
    @(posedge clk); #1;
    check("mid_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_valid", valid, 0);
    check("mid_chk_valid", chk_valid, 0);
    check("mid_food_x", food_x, 0);
    check("mid_lfsr", dut.lfsr, 16'hACE1);
    exp_fx = '0;
    exp_fy = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_vec(0);

`ifdef RANDOM_FOOD_BORDER_EN
    n_sweep = 10000;
`else
    n_sweep = 300;
`endif
    bad_x = 0; bad_y = 0; timeouts = 0; n_ok = 0;
    for (int i = 0; i < n_sweep; i++) begin
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        if (valid) got = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      if (!got) timeouts++;
      else if (!fail) begin
        n_ok++;
`ifdef RANDOM_FOOD_BORDER_EN
        if (food_x % 10 != 0 || food_x < 10 || food_x > 620) bad_x++;
        if (food_y % 10 != 0 || food_y < 10 || food_y > 460) bad_y++;
`else
        if (food_x % 10 != 0 || food_x > 630) bad_x++;
        if (food_y % 10 != 0 || food_y > 470) bad_y++;
`endif
      end
      @(posedge clk); #1;
    end
    check("sweep_timeouts", timeouts, 0);
    check("sweep_bad_x", bad_x, 0);
    check("sweep_bad_y", bad_y, 0);
    check("sweep_some_success", (n_ok > 0), 1);

    while (cyc < 65540) @(posedge clk);
    #1;
    check("lfsr_never_zero", zero_hits, 0);
    check("lfsr_tracks_model", dut.lfsr, m_lfsr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
